// File: rtl/id_stage_pipe_if.sv
// Fetch-to-decode handshake: fetch (master) presents pc/instr with valid,
// decode (slave) answers with ready.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;

  modport master (output valid, output pc, output instr, input ready);
  modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/id_stage_pipe.sv
// RV32IM decode stage: regfile with optional write-through, operand forwarding,
// early branch/jump resolution and a valid/ready ID/EX register.
module id_stage_pipe #(
  parameter int      XLEN      = 32,
  parameter int      NREGS     = 32,
  parameter bit      WB_BYPASS = 1'b1,
  localparam int     RA        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_pipe_if.slave  if_bus,
  input  logic            wb_we_i,
  input  logic [RA-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [1:0]      fwd_a_sel_i,
  input  logic [1:0]      fwd_b_sel_i,
  input  logic [XLEN-1:0] fwd_mem_w_i,
  input  logic [XLEN-1:0] fwd_alu_m_i,
  input  logic [XLEN-1:0] fwd_alu_w_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RA-1:0]   ex_rs1_o,
  output logic [RA-1:0]   ex_rs2_o,
  output logic [RA-1:0]   ex_rd_o,
  output logic [6:0]      ex_opcode_o,
  output logic [2:0]      ex_funct3_o,
  output logic [6:0]      ex_funct7_o,
  output logic            ex_we_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            illegal_o
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1'b1);

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] mw, input logic [XLEN-1:0] am,
                                              input logic [XLEN-1:0] aw);
    case (sel)
      2'b00:   return rf;
      2'b01:   return mw;
      2'b10:   return am;
      2'b11:   return aw;
      default: return rf;
    endcase
  endfunction

  logic [XLEN-1:0] rf_q [NREGS];
  logic [31:0]     instr_s;
  logic [6:0]      opcode_s, funct7_s;
  logic [2:0]      funct3_s;
  logic [RA-1:0]   rs1_raw_s, rs2_raw_s, rd_raw_s;
  logic [XLEN-1:0] rf_a_s, rf_b_s, a_s, b_s, imm_s, target_s;
  logic            known_s, use_rs1_s, use_rs2_s, use_rd_s, writes_s, is_jalr_s, is_branch_s;
  logic            taken_s, bad_f3_s, misalign_s, illegal_s, redirect_s, we_s, accept_s;

  logic            ex_valid_q, ex_we_q, redirect_q, illegal_q;
  logic [XLEN-1:0] ex_pc_q, ex_a_q, ex_b_q, ex_imm_q, redirect_pc_q;
  logic [RA-1:0]   ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [6:0]      ex_opcode_q, ex_funct7_q;
  logic [2:0]      ex_funct3_q;

  assign instr_s   = if_bus.instr;
  assign opcode_s  = instr_s[6:0];
  assign funct3_s  = instr_s[14:12];
  assign funct7_s  = instr_s[31:25];
  assign rs1_raw_s = RA'(instr_s[19:15]);
  assign rs2_raw_s = RA'(instr_s[24:20]);
  assign rd_raw_s  = RA'(instr_s[11:7]);

  assign if_bus.ready = !ex_valid_q || ex_ready_i;
  assign accept_s     = if_bus.valid && if_bus.ready && !flush_i;

  // Regfile write port; entry 0 is never written so x0 stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we_i && (wb_rd_i != '0)) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Regfile reads with write-through, then forwarding (data uses the raw field index).
  always_comb begin
    rf_a_s = '0;
    rf_b_s = '0;
    if (rs1_raw_s == '0) rf_a_s = '0;
    else if (WB_BYPASS && wb_we_i && (wb_rd_i == rs1_raw_s)) rf_a_s = wb_data_i;
    else rf_a_s = rf_q[rs1_raw_s];
    if (rs2_raw_s == '0) rf_b_s = '0;
    else if (WB_BYPASS && wb_we_i && (wb_rd_i == rs2_raw_s)) rf_b_s = wb_data_i;
    else rf_b_s = rf_q[rs2_raw_s];
    a_s = fwd_mux(fwd_a_sel_i, rf_a_s, fwd_mem_w_i, fwd_alu_m_i, fwd_alu_w_i);
    b_s = fwd_mux(fwd_b_sel_i, rf_b_s, fwd_mem_w_i, fwd_alu_m_i, fwd_alu_w_i);
  end

  // Format decode: immediate selection and which register fields are meaningful.
  always_comb begin
    known_s = 1'b1;  use_rs1_s = 1'b0;  use_rs2_s = 1'b0;  use_rd_s = 1'b1;
    writes_s = 1'b1; is_jalr_s = 1'b0;  is_branch_s = 1'b0;
    imm_s = '0;
    case (opcode_s)
      OP_LUI, OP_AUIPC: imm_s = XLEN'($signed({instr_s[31:12], 12'b0}));
      OP_JAL:  imm_s = XLEN'($signed({instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0}));
      OP_JALR: begin
        imm_s = XLEN'($signed(instr_s[31:20])); use_rs1_s = 1'b1; is_jalr_s = 1'b1;
      end
      OP_BRANCH: begin
        imm_s = XLEN'($signed({instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0}));
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b0; writes_s = 1'b0; is_branch_s = 1'b1;
      end
      OP_LOAD, OP_IMM: begin
        imm_s = XLEN'($signed(instr_s[31:20])); use_rs1_s = 1'b1;
      end
      OP_STORE: begin
        imm_s = XLEN'($signed({instr_s[31:25], instr_s[11:7]}));
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b0; writes_s = 1'b0;
      end
      OP_REG: begin
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      default: begin
        known_s = 1'b0; use_rd_s = 1'b0; writes_s = 1'b0;
      end
    endcase
  end

  // Early resolution: branch condition, target and legality.
  always_comb begin
    taken_s  = 1'b0;
    bad_f3_s = 1'b0;
    if (is_branch_s) begin
      case (funct3_s)
        3'b000:  taken_s = (a_s == b_s);
        3'b001:  taken_s = (a_s != b_s);
        3'b100:  taken_s = ($signed(a_s) <  $signed(b_s));
        3'b101:  taken_s = ($signed(a_s) >= $signed(b_s));
        3'b110:  taken_s = (a_s <  b_s);
        3'b111:  taken_s = (a_s >= b_s);
        default: bad_f3_s = 1'b1;
      endcase
    end else if ((opcode_s == OP_JAL) || is_jalr_s) begin
      taken_s = 1'b1;
    end else begin
      taken_s = 1'b0;
    end
    if (is_jalr_s) target_s = (a_s + imm_s) & LSB_CLR;
    else target_s = if_bus.pc + imm_s;
    misalign_s = taken_s && target_s[1];
    illegal_s  = !known_s || bad_f3_s || misalign_s;
    redirect_s = taken_s && !misalign_s;
    we_s       = writes_s && (rd_raw_s != '0) && !illegal_s;
  end

  // ID/EX boundary: flush beats accept, accept beats stall; pulses clear unless reloaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;  ex_pc_q <= '0;  ex_a_q <= '0;  ex_b_q <= '0;  ex_imm_q <= '0;
      ex_rs1_q <= '0;  ex_rs2_q <= '0;  ex_rd_q <= '0;
      ex_opcode_q <= '0;  ex_funct3_q <= '0;  ex_funct7_q <= '0;  ex_we_q <= 1'b0;
      redirect_q <= 1'b0;  redirect_pc_q <= '0;  illegal_q <= 1'b0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;  redirect_q <= 1'b0;  illegal_q <= 1'b0;
    end else if (accept_s) begin
      ex_valid_q  <= 1'b1;
      ex_pc_q     <= if_bus.pc;
      ex_a_q      <= a_s;
      ex_b_q      <= b_s;
      ex_imm_q    <= imm_s;
      ex_rs1_q    <= use_rs1_s ? rs1_raw_s : '0;
      ex_rs2_q    <= use_rs2_s ? rs2_raw_s : '0;
      ex_rd_q     <= use_rd_s  ? rd_raw_s  : '0;
      ex_opcode_q <= opcode_s;
      ex_funct3_q <= funct3_s;
      ex_funct7_q <= funct7_s;
      ex_we_q     <= we_s;
      redirect_q  <= redirect_s;
      redirect_pc_q <= target_s;
      illegal_q   <= illegal_s;
    end else begin
      ex_valid_q <= ex_valid_q && !ex_ready_i;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_rs1_data_o = ex_a_q;
  assign ex_rs2_data_o = ex_b_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rs1_o      = ex_rs1_q;
  assign ex_rs2_o      = ex_rs2_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_opcode_o   = ex_opcode_q;
  assign ex_funct3_o   = ex_funct3_q;
  assign ex_funct7_o   = ex_funct7_q;
  assign ex_we_o       = ex_we_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign illegal_o     = illegal_q;
endmodule
